// File: rtl/geofence_pkg.sv
// Shared definitions for the geofence datapath blocks.
//   COORD_W  default unsigned coordinate width
//   PT_W     width of one packed point {x,y}
//   CROSS_W  width of a signed cross-product result
//   wrap_inc helper for round-robin pointers: (v+1) mod n
package geofence_pkg;

    localparam int COORD_W = 10;
    localparam int PT_W    = 2 * COORD_W;
    localparam int CROSS_W = 2 * COORD_W + 3;

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/cross_product_pipe.sv
// Three-stage cross-product engine with tag/valid sideband.
//   S1: coordinate differences, S2: the two products, S3: subtraction and
//   one-hot response routing.
// Ports:
//   clk, reset          clock / asynchronous active-high reset
//   in_valid, in_tag    accepted operation and its requester index
//   in_p1, in_p2, in_ref  operand points, each {x,y}
//   rsp_valid           one-hot result strobe, indexed by tag
//   rsp_value, rsp_gt0  signed result and (result > 0), held between results
//   busy                any stage holds a valid operation
module cross_product_pipe
    import geofence_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int COORD_W = 10,
    parameter int TAG_W   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [TAG_W-1:0]       in_tag,
    input  logic [2*COORD_W-1:0]   in_p1,
    input  logic [2*COORD_W-1:0]   in_p2,
    input  logic [2*COORD_W-1:0]   in_ref,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [2*COORD_W+2:0]   rsp_value,
    output logic                   rsp_gt0,
    output logic                   busy
);

    localparam int DW = COORD_W + 1;       // difference width
    localparam int MW = 2 * COORD_W + 2;   // product width
    localparam int XW = 2 * COORD_W + 3;   // result width

    // Points are packed {x,y}; x is the upper half.
    logic [COORD_W-1:0] p1x, p1y, p2x, p2y, rx, ry;
    assign p1x = in_p1[2*COORD_W-1:COORD_W];
    assign p1y = in_p1[COORD_W-1:0];
    assign p2x = in_p2[2*COORD_W-1:COORD_W];
    assign p2y = in_p2[COORD_W-1:0];
    assign rx  = in_ref[2*COORD_W-1:COORD_W];
    assign ry  = in_ref[COORD_W-1:0];

    // Zero-extend before subtracting so the difference is never truncated.
    logic signed [DW-1:0] dx1_d, dy2_d, dx2_d, dy1_d;
    assign dx1_d = $signed({1'b0, p1x}) - $signed({1'b0, rx});
    assign dy2_d = $signed({1'b0, p2y}) - $signed({1'b0, ry});
    assign dx2_d = $signed({1'b0, p2x}) - $signed({1'b0, rx});
    assign dy1_d = $signed({1'b0, p1y}) - $signed({1'b0, ry});

    logic signed [DW-1:0] dx1_q, dy2_q, dx2_q, dy1_q;
    logic [TAG_W-1:0]     tag1_q, tag2_q;
    logic                 v1_q, v2_q;
    logic signed [MW-1:0] m1_q, m2_q;
    logic [NREQ-1:0]      rsp_valid_q;
    logic [XW-1:0]        rsp_value_q;
    logic                 rsp_gt0_q;

    // Operands are sign-extended to the product width so the multiply is
    // evaluated at full precision.
    logic signed [MW-1:0] m1_d, m2_d;
    assign m1_d = $signed({{(MW-DW){dx1_q[DW-1]}}, dx1_q}) * $signed({{(MW-DW){dy2_q[DW-1]}}, dy2_q});
    assign m2_d = $signed({{(MW-DW){dx2_q[DW-1]}}, dx2_q}) * $signed({{(MW-DW){dy1_q[DW-1]}}, dy1_q});

    logic signed [XW-1:0] value_d;
    assign value_d = $signed({m1_q[MW-1], m1_q}) - $signed({m2_q[MW-1], m2_q});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dx1_q       <= '0;
            dy2_q       <= '0;
            dx2_q       <= '0;
            dy1_q       <= '0;
            tag1_q      <= '0;
            v1_q        <= 1'b0;
            m1_q        <= '0;
            m2_q        <= '0;
            tag2_q      <= '0;
            v2_q        <= 1'b0;
            rsp_valid_q <= '0;
            rsp_value_q <= '0;
            rsp_gt0_q   <= 1'b0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                dx1_q  <= dx1_d;
                dy2_q  <= dy2_d;
                dx2_q  <= dx2_d;
                dy1_q  <= dy1_d;
                tag1_q <= in_tag;
            end
            v2_q <= v1_q;
            if (v1_q) begin
                m1_q   <= m1_d;
                m2_q   <= m2_d;
                tag2_q <= tag1_q;
            end
            // Result registers hold their last value when no result arrives.
            rsp_valid_q <= v2_q ? (NREQ'(1) << tag2_q) : '0;
            if (v2_q) begin
                rsp_value_q <= value_d;
                rsp_gt0_q   <= !value_d[XW-1] && (|value_d);
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_value = rsp_value_q;
    assign rsp_gt0   = rsp_gt0_q;
    assign busy      = v1_q | v2_q | (|rsp_valid_q);

endmodule

// File: rtl/cross_product_scheduler.sv
// Shares one cross-product pipeline between NREQ requesters.
// A round-robin arbiter accepts one operand triple per cycle; results return
// in acceptance order, routed to the requester by a one-hot rsp_valid.
// Handshake: a requester holds req_valid and its operands stable until it
// sees req_ready; the transfer happens on the rising edge where both are 1.
// It may drop req_valid before a grant, in which case the request is lost.
// Ports:
//   clk, reset                clock / asynchronous active-high reset
//   req_valid, req_ready      per-requester handshake (at most one ready)
//   req_p1, req_p2, req_ref   packed operand points, slice i = requester i
//   rsp_valid                 one-hot, one cycle, never held
//   rsp_value, rsp_gt0        signed cross product and (value > 0)
//   busy                      an operation is in flight
module cross_product_scheduler
    import geofence_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int COORD_W = 10
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ*2*COORD_W-1:0]   req_p1,
    input  logic [NREQ*2*COORD_W-1:0]   req_p2,
    input  logic [NREQ*2*COORD_W-1:0]   req_ref,
    output logic [NREQ-1:0]             rsp_valid,
    output logic [2*COORD_W+2:0]        rsp_value,
    output logic                        rsp_gt0,
    output logic                        busy
);

    localparam int P_W   = 2 * COORD_W;
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] rr_q, rr_d;
    logic [PTR_W-1:0] gnt_idx;
    logic             gnt_any;

    // Search upward from the pointer, wrapping mod NREQ; first valid wins.
    always_comb begin
        req_ready = '0;
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        for (int off = 0; off < NREQ; off++) begin
            int idx;
            idx = int'(rr_q) + off;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_any && !reset && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = PTR_W'(idx);
            end
        end
        if (gnt_any) req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        rr_d = rr_q;
        if (gnt_any) rr_d = PTR_W'(wrap_inc(32'(gnt_idx), NREQ));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_q <= '0;
        else       rr_q <= rr_d;
    end

    logic [P_W-1:0] sel_p1, sel_p2, sel_ref;
    assign sel_p1  = req_p1[int'(gnt_idx)*P_W +: P_W];
    assign sel_p2  = req_p2[int'(gnt_idx)*P_W +: P_W];
    assign sel_ref = req_ref[int'(gnt_idx)*P_W +: P_W];

    cross_product_pipe #(
        .NREQ    (NREQ),
        .COORD_W (COORD_W),
        .TAG_W   (PTR_W)
    ) u_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (gnt_any),
        .in_tag    (gnt_idx),
        .in_p1     (sel_p1),
        .in_p2     (sel_p2),
        .in_ref    (sel_ref),
        .rsp_valid (rsp_valid),
        .rsp_value (rsp_value),
        .rsp_gt0   (rsp_gt0),
        .busy      (busy)
    );

endmodule
